// File: rtl/arith_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arith_pkg
// Description : Shared opcode constants, FSM state encoding and helpers for
//               the arith_unit block and its combinational core.
// Revision    : 1.0 - initial release
// ============================================================================
package arith_pkg;

    // Operation codes
    localparam logic [2:0] c_op_add = 3'b000;
    localparam logic [2:0] c_op_adc = 3'b001;
    localparam logic [2:0] c_op_sub = 3'b010;
    localparam logic [2:0] c_op_sbb = 3'b011;
    localparam logic [2:0] c_op_cmp = 3'b100;
    localparam logic [2:0] c_op_neg = 3'b101;

    // FSM state encoding
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_load = 2'd1;
    localparam logic [1:0] c_st_exec = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = c_st_idle,
        ST_LOAD = c_st_load,
        ST_EXEC = c_st_exec,
        ST_DONE = c_st_done
    } state_t;

    // Codes 110/111 are reserved and leave result and flags untouched.
    function automatic logic op_is_valid(input logic [2:0] op);
        return (op <= c_op_neg);
    endfunction

endpackage : arith_pkg
`default_nettype wire

// File: rtl/arith_core.sv
`default_nettype none
// ============================================================================
// Module      : arith_core
// Description : Combinational datapath of arith_unit. Selects the effective
//               addends for the requested operation, forms a WIDTH+1 bit sum
//               and derives the next result plus NZCV flags and the write
//               enables for the result / flag registers.
//               Optional saturation is compiled in with `define ARITH_SAT_EN.
// Ports       : i_a, i_b     registered operands
//               i_op         operation code
//               i_cin        carry in (ADC) / not-borrow (SBB)
//               i_sat        saturate request (used only with ARITH_SAT_EN)
//               o_result     next result value
//               o_cout/o_zero/o_neg/o_ovf  next flags
//               o_wr_result  result register should load
//               o_wr_flags   flag registers should load
// Revision    : 1.0 - initial release
// ============================================================================
module arith_core
    import arith_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [2:0]       i_op,
    input  logic             i_cin,
    input  logic             i_sat,
    output logic [WIDTH-1:0] o_result,
    output logic             o_cout,
    output logic             o_zero,
    output logic             o_neg,
    output logic             o_ovf,
    output logic             o_wr_result,
    output logic             o_wr_flags
);

    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_y;
    logic             w_c;
    logic [WIDTH:0]   w_sum;
    logic             w_ovf;
    logic [WIDTH-1:0] w_val;

    // Every operation is expressed as x + y + c with one adder.
    always_comb begin
        w_x = i_a;
        w_y = i_b;
        w_c = 1'b0;
        case (i_op)
            c_op_add: ;
            c_op_adc: w_c = i_cin;
            c_op_sub,
            c_op_cmp: begin
                w_y = ~i_b;
                w_c = 1'b1;
            end
            c_op_sbb: begin
                w_y = ~i_b;
                w_c = i_cin;
            end
            c_op_neg: begin
                w_x = '0;
                w_y = ~i_a;
                w_c = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_c};

    // Signed overflow: like-signed addends producing an opposite-signed sum.
    assign w_ovf = (w_x[WIDTH-1] == w_y[WIDTH-1]) && (w_sum[WIDTH-1] != w_x[WIDTH-1]);

`ifdef ARITH_SAT_EN
    logic w_clamp;

    // CMP never writes the result, so it is never clamped; its flags come
    // from the raw difference.
    assign w_clamp = i_sat && w_ovf && (i_op != c_op_cmp);

    always_comb begin
        w_val = w_sum[WIDTH-1:0];
        if (w_clamp) begin
            w_val = w_x[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    logic w_unused_sat;

    assign w_unused_sat = i_sat;
    assign w_val        = w_sum[WIDTH-1:0];
`endif

    assign o_result    = w_val;
    assign o_cout      = w_sum[WIDTH];
    assign o_zero      = (w_val == '0);
    assign o_neg       = w_val[WIDTH-1];
    assign o_ovf       = w_ovf;
    assign o_wr_flags  = op_is_valid(i_op);
    assign o_wr_result = op_is_valid(i_op) && (i_op != c_op_cmp);

endmodule : arith_core
`default_nettype wire

// File: rtl/arith_unit.sv
`default_nettype none
// ============================================================================
// Module      : arith_unit
// Description : Multi-operation integer arithmetic unit (ADD/ADC/SUB/SBB/
//               CMP/NEG) with a cs/rdy handshake, registered result and
//               NZCV-style flags. A request is accepted on an edge where
//               cs=1 and rdy=1; done pulses for one cycle three edges later.
//               Optional saturation: `define ARITH_SAT_EN.
// Ports       : clk, rst     clock, synchronous active-high reset
//               cs           request (sampled only while rdy=1)
//               op, a, b     operation code and operands
//               cin          carry in / not-borrow
//               sat          saturate request
//               result       registered result
//               cout, zero, neg, ovf   registered flags
//               rdy          unit can accept a request
//               done         one-cycle pulse, result and flags valid
// Revision    : 1.0 - initial release
// ============================================================================
module arith_unit
    import arith_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cs,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sat,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             rdy,
    output logic             done
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic             r_cin;
    logic             r_sat;

    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_zero;
    logic             r_neg;
    logic             r_ovf;

    logic [WIDTH-1:0] w_core_result;
    logic             w_core_cout;
    logic             w_core_zero;
    logic             w_core_neg;
    logic             w_core_ovf;
    logic             w_core_wr_result;
    logic             w_core_wr_flags;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        rdy         = 1'b0;
        done        = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                rdy      = 1'b1;
                w_accept = cs;
                if (cs) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                rdy         = 1'b1;
                done        = 1'b1;
                w_accept    = cs;
                // Chaining from DONE keeps back-to-back issue at 3 cycles.
                w_state_nxt = cs ? ST_LOAD : ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand capture: frozen from the accept edge so later input changes
    // cannot disturb the operation in flight.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_op  <= c_op_add;
            r_cin <= 1'b0;
            r_sat <= 1'b0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_op  <= op;
            r_cin <= cin;
            r_sat <= sat;
        end
    end

    arith_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_a         (r_a),
        .i_b         (r_b),
        .i_op        (r_op),
        .i_cin       (r_cin),
        .i_sat       (r_sat),
        .o_result    (w_core_result),
        .o_cout      (w_core_cout),
        .o_zero      (w_core_zero),
        .o_neg       (w_core_neg),
        .o_ovf       (w_core_ovf),
        .o_wr_result (w_core_wr_result),
        .o_wr_flags  (w_core_wr_flags)
    );

    // ------------------------------------------------------------------
    // Output registers: loaded on the EXEC->DONE edge and held otherwise.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
            r_cout   <= 1'b0;
            r_zero   <= 1'b0;
            r_neg    <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            if (w_core_wr_result) begin
                r_result <= w_core_result;
            end
            if (w_core_wr_flags) begin
                r_cout <= w_core_cout;
                r_zero <= w_core_zero;
                r_neg  <= w_core_neg;
                r_ovf  <= w_core_ovf;
            end
        end
    end

    assign result = r_result;
    assign cout   = r_cout;
    assign zero   = r_zero;
    assign neg    = r_neg;
    assign ovf    = r_ovf;

endmodule : arith_unit
`default_nettype wire

// File: tb/tb_arith_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_arith_unit
// Description : Directed self-checking bench for arith_unit (WIDTH=16).
//               Flag vectors are packed as {cout, zero, neg, ovf}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arith_unit;

    logic        clk;
    logic        rst;
    logic        cs;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sat;
    logic [15:0] result;
    logic        cout;
    logic        zero;
    logic        neg;
    logic        ovf;
    logic        rdy;
    logic        done;

    int checks = 0;
    int errors = 0;

    arith_unit #(
        .WIDTH (16)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .cs     (cs),
        .op     (op),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .sat    (sat),
        .result (result),
        .cout   (cout),
        .zero   (zero),
        .neg    (neg),
        .ovf    (ovf),
        .rdy    (rdy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request and wait (bounded) for done. Returns edges after accept.
    task automatic do_op(input logic [2:0] o, input logic [15:0] xa, input logic [15:0] xb,
                         input logic c, input logic s, output int lat);
        op  = o;
        a   = xa;
        b   = xb;
        cin = c;
        sat = s;
        cs  = 1'b1;
        @(posedge clk); #1;
        cs  = 1'b0;
        a   = 16'hDEAD;
        b   = 16'hBEEF;
        lat = 0;
        while (!done && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int          lat;
        int          dcount;
        logic [15:0] ea [9];
        rst = 1'b1; cs = 1'b0; op = 3'b000; a = '0; b = '0; cin = 1'b0; sat = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_result", {16'h0, result}, 32'h0);
        chk("reset_flags", {28'h0, cout, zero, neg, ovf}, 32'h0);
        chk("reset_rdy_done", {30'h0, rdy, done}, 32'h2);
        rst = 1'b0;
        @(posedge clk); #1;

        // ADD FFFF+0001
        do_op(3'b000, 16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
        chk("add_latency", lat, 2);
        chk("add_result", {16'h0, result}, 32'h0000);
        chk("add_flags", {28'h0, cout, zero, neg, ovf}, 32'hC);
        chk("add_rdy_done", {30'h0, rdy, done}, 32'h3);

        // SUB 8000-0001
        do_op(3'b010, 16'h8000, 16'h0001, 1'b0, 1'b0, lat);
        chk("sub_result", {16'h0, result}, 32'h7FFF);
        chk("sub_flags", {28'h0, cout, zero, neg, ovf}, 32'h9);

        // SBB 5,3 cin=0
        do_op(3'b011, 16'h0005, 16'h0003, 1'b0, 1'b0, lat);
        chk("sbb_result", {16'h0, result}, 32'h0001);
        chk("sbb_flags", {28'h0, cout, zero, neg, ovf}, 32'h8);

        // ADC 7FFF+0+1
        do_op(3'b001, 16'h7FFF, 16'h0000, 1'b1, 1'b0, lat);
        chk("adc_result", {16'h0, result}, 32'h8000);
        chk("adc_flags", {28'h0, cout, zero, neg, ovf}, 32'h3);

        // NEG 0001
        do_op(3'b101, 16'h0001, 16'h0000, 1'b0, 1'b0, lat);
        chk("neg_result", {16'h0, result}, 32'hFFFF);
        chk("neg_flags", {28'h0, cout, zero, neg, ovf}, 32'h2);

        // Establish 0x1234, then CMP must leave it alone
        do_op(3'b000, 16'h1000, 16'h0234, 1'b0, 1'b0, lat);
        chk("pre_cmp_result", {16'h0, result}, 32'h1234);
        chk("pre_cmp_flags", {28'h0, cout, zero, neg, ovf}, 32'h0);
        do_op(3'b100, 16'h0003, 16'h0003, 1'b0, 1'b0, lat);
        chk("cmp_result", {16'h0, result}, 32'h1234);
        chk("cmp_flags", {28'h0, cout, zero, neg, ovf}, 32'hC);

        // Reserved opcode: done pulses, nothing changes
        do_op(3'b110, 16'h0F0F, 16'h7777, 1'b1, 1'b0, lat);
        chk("rsv_latency", lat, 2);
        chk("rsv_done", {31'h0, done}, 32'h1);
        chk("rsv_result", {16'h0, result}, 32'h1234);
        chk("rsv_flags", {28'h0, cout, zero, neg, ovf}, 32'hC);
        @(posedge clk); #1;
        chk("done_single_pulse", {30'h0, rdy, done}, 32'h2);

        // Saturating ADD 7FFF+0001
        do_op(3'b000, 16'h7FFF, 16'h0001, 1'b0, 1'b1, lat);
`ifdef ARITH_SAT_EN
        chk("sat_result", {16'h0, result}, 32'h7FFF);
        chk("sat_flags", {28'h0, cout, zero, neg, ovf}, 32'h1);
`else
        chk("sat_result", {16'h0, result}, 32'h8000);
        chk("sat_flags", {28'h0, cout, zero, neg, ovf}, 32'h3);
`endif

        // cs held for 9 edges, operands changing each cycle: accepts at
        // edges 0, 3, 6 (chained from DONE), done after edges 2, 5, 8.
        dcount = 0;
        for (int k = 0; k < 9; k++) begin
            op    = 3'b000;
            cin   = 1'b0;
            sat   = 1'b0;
            a     = 16'h1000 + 16'(k) * 16'h0101;
            b     = 16'(k) * 16'h0011;
            ea[k] = a + b;
            cs    = 1'b1;
            @(posedge clk); #1;
            if (done) dcount++;
            chk($sformatf("chain_done_%0d", k), {31'h0, done}, {31'h0, ((k % 3) == 2)});
            if ((k % 3) == 2) begin
                chk($sformatf("chain_result_%0d", k), {16'h0, result}, {16'h0, ea[k-2]});
            end
        end
        cs = 1'b0;
        @(posedge clk); #1;
        if (done) dcount++;
        chk("chain_idle_rdy", {30'h0, rdy, done}, 32'h2);
        chk("chain_ops", dcount, 3);

        // Reset while in EXEC aborts without done
        op = 3'b000; a = 16'h0101; b = 16'h0202; cs = 1'b1;
        @(posedge clk); #1;
        cs = 1'b0;
        @(posedge clk); #1;
        chk("abort_in_exec_rdy", {31'h0, rdy}, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_rdy_done", {30'h0, rdy, done}, 32'h2);
        chk("abort_result", {16'h0, result}, 32'h0);
        chk("abort_flags", {28'h0, cout, zero, neg, ovf}, 32'h0);
        dcount = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        chk("abort_no_done", dcount, 0);

        // Reset and cs together: request dropped
        rst = 1'b1; cs = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; cs = 1'b0;
        @(posedge clk); #1;
        chk("rst_beats_cs", {30'h0, rdy, done}, 32'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_arith_unit
`default_nettype wire
